rf_writeback: RTL
=================

Name: rf_writeback

Overview:
- Writeback stage directly upstream of the register file write port (wen/waddr/wdata, 5-bit address, 32-bit data).
- Merges two result sources into one write per cycle:
  - the single-cycle execute path, which is never stalled;
  - a long-latency path (load / mul-div), buffered in a small FIFO with valid/ready handshake.
- Keeps a busy scoreboard of destination registers with outstanding long-latency results, for the decode-stage hazard check.

Parameters:
- DEPTH, 4, long-latency FIFO entries (power of two, >=2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  execute result valid this cycle
- ex_rd  in  AW  execute destination register
- ex_data  in  DW  execute result
- ll_valid  in  1  long-latency result valid
- ll_ready  out  1  FIFO can accept (= !full)
- ll_rd  in  AW  long-latency destination register
- ll_data  in  DW  long-latency result
- issue_valid  in  1  decode issues a long-latency op this cycle
- issue_rd  in  AW  its destination register
- busy  out  2**AW  per-register outstanding-write mask
- rf_wen  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  DW  register file write data
- ll_count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: clk and rst as already decided (rst synchronous, active-high); the whole block is synchronous to clk.
  - rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, ll_count=0, FIFO pointers=0, ll_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all FIFO contents and pending busy bits. No rf_wen is generated for discarded entries.
- Output registers:
  - rf_wen, rf_waddr and rf_wdata are registered.
  - rf_waddr and rf_wdata hold their last value when rf_wen=0.
- Selection each cycle (combinational, then registered):
  - ex_valid && ex_rd!=0: write the ex result. The FIFO does not pop.
  - otherwise, if the FIFO is non-empty: pop the head and write it.
  - otherwise: rf_wen=0 next cycle.
- Write to x0: never produced on rf_wen.
  - ex with rd=0 is ignored and frees the slot for a FIFO pop.
- Latency:
  - ex accepted at edge N gives rf_wen high in cycle N+1.
  - ll push at edge N gives rf_wen high at the earliest in cycle N+2. There is no bypass from ll_* to the output; an empty-FIFO push is only poppable next cycle.
- FIFO handshake:
  - push = ll_valid && ll_ready && ll_rd!=0.
  - ll_valid with ll_rd=0 is accepted (handshake completes) and dropped.
  - ll_ready depends only on full, not on a same-cycle pop. A full FIFO with a pop still deasserts ready.
  - Pointers wrap modulo DEPTH; ll_count tracks push minus pop.
  - Simultaneous push and pop leaves the count unchanged.
- Starvation: continuous ex traffic may stall FIFO pops indefinitely. This is accepted because the ex stream has bubbles in practice. ll_ready backpressures the source.
- Scoreboard:
  - busy[issue_rd] sets on issue_valid && issue_rd!=0.
  - busy[rd] clears on the edge the FIFO pop for rd is registered, i.e. in the same cycle rf_wen rises for it.
  - Same-cycle set and clear of the same rd: set wins.
  - busy[0] is always 0.
- Illegal input conditions (simulation assertions; the RTL does not guard against them):
  - issue_rd already busy;
  - ex_valid with ex_rd busy;
  - ll push for an rd that is not busy;
  - push while full.

Decomposition:
- Shared package rf_pkg holds:
  - constants REG_AW=5, REG_DW=32, REG_ZERO=5'd0;
  - typedef wb_entry_t {rd, data}.
- Sub-module rf_wb_fifo (sync FIFO, DEPTH x wb_entry_t, push/pop/full/empty/count).
  - Selection, output registers and the scoreboard stay in rf_writeback.

Test Plan:
- Reset, then ex_valid=1, ex_rd=3, ex_data=0x1234_5678 for 1 cycle -> rf_wen=1, waddr=3, wdata=0x12345678 exactly one cycle later; rf_wen=0 after that.
- issue rd=7, then ll push rd=7, data=0xDEAD_BEEF with ex idle -> rf_wen with waddr=7 two cycles after the push; busy[7] is 1 from the issue edge and 0 on the cycle rf_wen is high.
- ex_valid held high with rd=1..8 while 4 ll results are pushed -> ll_count=4, ll_ready=0; no ll write until ex drops; then 4 consecutive ll writes in FIFO order; ll_count returns to 0.
- ex_rd=0 with ex_valid=1 and a non-empty FIFO -> the FIFO head is written that cycle; no write to x0.
- ll push with ll_rd=0 -> handshake accepted, ll_count unchanged, no rf_wen.
- FIFO holds 3 entries and busy={5,6,9}, then rst=1 for 1 cycle -> busy=0, ll_count=0, rf_wen=0; no stale writes in the following 5 cycles.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file writeback definitions: architectural widths and the
// long-latency result entry carried through the writeback FIFO.
package rf_pkg;
   localparam int REG_AW = 5;
   localparam int REG_DW = 32;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [REG_DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO buffering long-latency writeback results until the
// register file write port is free of execute traffic.
module rf_wb_fifo
   import rf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  wb_entry_t                din,
   output wb_entry_t                head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   wb_entry_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // Storage carries no reset; occupancy and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

   a_no_overflow:  assert property (@(posedge clk) disable iff (rst) push |-> !full);
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);
endmodule

// File: rtl/rf_writeback.sv
// Writeback stage: merges the never-stalled execute result with buffered
// long-latency results into one register file write per cycle, and tracks
// destination registers that still have a long-latency write outstanding.
module rf_writeback
   import rf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = REG_AW,
   parameter int DW    = REG_DW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ex_valid,
   input  logic [AW-1:0]            ex_rd,
   input  logic [DW-1:0]            ex_data,
   input  logic                     ll_valid,
   output logic                     ll_ready,
   input  logic [AW-1:0]            ll_rd,
   input  logic [DW-1:0]            ll_data,
   input  logic                     issue_valid,
   input  logic [AW-1:0]            issue_rd,
   output logic [2**AW-1:0]         busy,
   output logic                     rf_wen,
   output logic [AW-1:0]            rf_waddr,
   output logic [DW-1:0]            rf_wdata,
   output logic [$clog2(DEPTH):0]   ll_count
);
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic        ex_take;
   wb_entry_t   din;
   wb_entry_t   head;
   logic [2**AW-1:0] busy_nxt;

   // Ready reflects only fullness so the source never sees a pop-dependent path.
   assign ll_ready = !full;
   // rd=0 results complete the handshake but are never stored.
   assign push     = ll_valid && ll_ready && (ll_rd != REG_ZERO);
   assign ex_take  = ex_valid && (ex_rd != REG_ZERO);
   assign pop      = !ex_take && !empty;
   assign din      = '{rd: ll_rd, data: ll_data};

   rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (ll_count)
   );

   // Clear for the popped rd first so a same-cycle reissue of that rd stays set.
   always_comb begin
      busy_nxt = busy;
      if (pop) busy_nxt[head.rd] = 1'b0;
      if (issue_valid && (issue_rd != REG_ZERO)) busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wen   <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         busy     <= '0;
      end else begin
         busy   <= busy_nxt;
         rf_wen <= ex_take || pop;
         if (ex_take) begin
            rf_waddr <= ex_rd;
            rf_wdata <= ex_data;
         end else if (pop) begin
            rf_waddr <= head.rd;
            rf_wdata <= head.data;
         end
      end
   end

   a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
      (issue_valid && issue_rd != REG_ZERO) |-> !busy[issue_rd]);
   a_ex_not_busy: assert property (@(posedge clk) disable iff (rst)
      (ex_valid && ex_rd != REG_ZERO) |-> !busy[ex_rd]);
   a_push_busy: assert property (@(posedge clk) disable iff (rst)
      push |-> busy[ll_rd]);
endmodule
